// File: rtl/des_key_dec.sv
// DES round-key generator: walks the key schedule backwards from a PC-1 key (K16..K1).
// Optional DES_KEY_DEC_FWD_EN adds mode_in for forward (K1..K16) emission.
module des_key_dec #(
    parameter int ROUND_NUM = 16
) (
    input  logic        clk_in,
    input  logic        rst_n_in,
    input  logic [55:0] sub_key_in,
    input  logic        sub_key_in_valid,
`ifdef DES_KEY_DEC_FWD_EN
    input  logic        mode_in,
`endif
    output logic        sub_key_in_ready_out,
    output logic [47:0] key_out,
    output logic [3:0]  key_idx_out,
    output logic        key_out_valid,
    input  logic        key_out_ready_in,
    output logic        done_out
);

    localparam logic [3:0] LAST_DEC = 4'(16 - ROUND_NUM);
    localparam logic [3:0] LAST_FWD = 4'(ROUND_NUM - 1);

    // 1-based bit numbers into {C,D}, bit 1 being the MSB
    localparam int PC2_TBL [48] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
    };

    typedef enum logic [1:0] {IDLE, EMIT, DONE} state_t;

    function automatic logic two_shift(input logic [3:0] idx);
        return !(idx == 4'd0 || idx == 4'd1 || idx == 4'd8 || idx == 4'd15);
    endfunction

    function automatic logic [27:0] rotl28(input logic [27:0] x, input logic two);
        return two ? {x[25:0], x[27:26]} : {x[26:0], x[27]};
    endfunction

    function automatic logic [27:0] rotr28(input logic [27:0] x, input logic two);
        return two ? {x[1:0], x[27:2]} : {x[0], x[27:1]};
    endfunction

    function automatic logic [47:0] pc2(input logic [55:0] cd);
        logic [47:0] k;
        k = '0;
        for (int i = 0; i < 48; i++) begin
            k[6'(47 - i)] = cd[6'(56 - PC2_TBL[i])];
        end
        return k;
    endfunction

    state_t      state_q;
    logic [27:0] c_q, d_q;
    logic [3:0]  idx_q;
    logic [47:0] key_q;
    logic        vld_q;
    logic        done_q;
    logic        fwd_q;

    logic        fwd_acc_d;
    logic [27:0] c_acc_d, d_acc_d;
    logic [27:0] c_nxt_d, d_nxt_d;
    logic [3:0]  idx_nxt_d;
    logic        last_d;

    always_comb begin
        fwd_acc_d = 1'b0;
`ifdef DES_KEY_DEC_FWD_EN
        fwd_acc_d = mode_in;
`endif
        c_acc_d = sub_key_in[55:28];
        d_acc_d = sub_key_in[27:0];
        // Forward order must already hold C1/D1 when K1 is presented
        if (fwd_acc_d) begin
            c_acc_d = rotl28(sub_key_in[55:28], two_shift(4'd0));
            d_acc_d = rotl28(sub_key_in[27:0], two_shift(4'd0));
        end

        if (fwd_q) begin
            idx_nxt_d = idx_q + 4'd1;
            c_nxt_d   = rotl28(c_q, two_shift(idx_nxt_d));
            d_nxt_d   = rotl28(d_q, two_shift(idx_nxt_d));
            last_d    = (idx_q == LAST_FWD);
        end else begin
            // Undo the left shift that produced the key just consumed
            idx_nxt_d = idx_q - 4'd1;
            c_nxt_d   = rotr28(c_q, two_shift(idx_q));
            d_nxt_d   = rotr28(d_q, two_shift(idx_q));
            last_d    = (idx_q == LAST_DEC);
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q <= IDLE;
            c_q     <= '0;
            d_q     <= '0;
            idx_q   <= '0;
            key_q   <= '0;
            vld_q   <= 1'b0;
            done_q  <= 1'b0;
            fwd_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (sub_key_in_valid) begin
                        c_q     <= c_acc_d;
                        d_q     <= d_acc_d;
                        idx_q   <= fwd_acc_d ? 4'd0 : 4'd15;
                        key_q   <= pc2({c_acc_d, d_acc_d});
                        vld_q   <= 1'b1;
                        fwd_q   <= fwd_acc_d;
                        state_q <= EMIT;
                    end
                end
                EMIT: begin
                    if (key_out_ready_in) begin
                        if (last_d) begin
                            vld_q   <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= DONE;
                        end else begin
                            c_q   <= c_nxt_d;
                            d_q   <= d_nxt_d;
                            idx_q <= idx_nxt_d;
                            key_q <= pc2({c_nxt_d, d_nxt_d});
                        end
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    vld_q   <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign sub_key_in_ready_out = (state_q == IDLE);
    assign key_out              = key_q;
    assign key_idx_out          = idx_q;
    assign key_out_valid        = vld_q;
    assign done_out             = done_q;

endmodule
